// File: rtl/decode_stage_pkg.sv
// Opcode/funct/FPU codes and decoded-field struct shared by the decode stage.
// The decode helper is pure combinational; callers register its result.
package constant;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_FPU     = 6'h11;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_LW_S    = 6'h31;
  localparam logic [5:0] OP_SW_S    = 6'h39;
  localparam logic [5:0] OP_IN      = 6'h3e;
  localparam logic [5:0] OP_OUT     = 6'h3f;

  localparam logic [5:0] FUNC_SLL = 6'h00;
  localparam logic [5:0] FUNC_SRL = 6'h02;
  localparam logic [5:0] FUNC_JR  = 6'h08;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_SLT = 6'h2a;

  localparam logic [5:0] FPU_ADD = 6'h00;
  localparam logic [5:0] FPU_SUB = 6'h01;
  localparam logic [5:0] FPU_MUL = 6'h02;
  localparam logic [5:0] FPU_DIV = 6'h03;
  localparam logic [5:0] FPU_MOV = 6'h06;
  localparam logic [5:0] FPU_NEG = 6'h07;

  localparam logic [1:0] OPTYPE_I = 2'b00;
  localparam logic [1:0] OPTYPE_R = 2'b01;
  localparam logic [1:0] OPTYPE_F = 2'b10;

  localparam logic [5:0] REG_RA = 6'd31;

  typedef struct packed {
    logic [1:0]  op_type;
    logic [5:0]  instr;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic [31:0] imm;
    logic        use_rs;
    logic        use_rt;
    logic        branch;
    logic        jump;
    logic        is_jr;
    logic        is_jal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t r;
    logic [5:0] op;
    logic [5:0] fn;
    op       = ir[31:26];
    fn       = ir[5:0];
    r        = '0;
    r.rs     = {1'b0, ir[25:21]};
    r.rt     = {1'b0, ir[20:16]};
    r.imm    = {{16{ir[15]}}, ir[15:0]};
    if (op == OP_SPECIAL) begin
      r.op_type = OPTYPE_R;
      r.instr   = fn;
      r.rd      = {1'b0, ir[15:11]};
      r.imm     = {16'b0, ir[15:0]};
      r.use_rs  = 1'b1;
      r.use_rt  = (fn != FUNC_JR);
      r.is_jr   = (fn == FUNC_JR);
    end else if (op == OP_FPU) begin
      r.op_type = OPTYPE_F;
      r.instr   = fn;
      r.rs      = {1'b1, ir[25:21]};
      r.rt      = {1'b1, ir[20:16]};
      r.rd      = {1'b1, ir[15:11]};
      r.imm     = {16'b0, ir[15:0]};
      r.use_rs  = 1'b1;
      r.use_rt  = 1'b1;
    end else begin
      r.op_type = OPTYPE_I;
      r.instr   = op;
      case (op)
        OP_ANDI, OP_ORI, OP_XORI: begin
          r.imm    = {16'b0, ir[15:0]};
          r.rd     = r.rt;
          r.use_rs = 1'b1;
        end
        OP_LUI: begin
          r.imm = {16'b0, ir[15:0]};
          r.rd  = r.rt;
        end
        OP_ADDI, OP_SLTI, OP_LW: begin
          r.rd     = r.rt;
          r.use_rs = 1'b1;
        end
        OP_LW_S: begin
          r.rt     = {1'b1, ir[20:16]};
          r.rd     = r.rt;
          r.use_rs = 1'b1;
        end
        OP_SW: begin
          r.use_rs = 1'b1;
          r.use_rt = 1'b1;
        end
        OP_SW_S: begin
          r.rt     = {1'b1, ir[20:16]};
          r.use_rs = 1'b1;
          r.use_rt = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          r.branch = 1'b1;
          r.use_rs = 1'b1;
          r.use_rt = 1'b1;
        end
        OP_BLEZ, OP_BGTZ: begin
          r.branch = 1'b1;
          r.use_rs = 1'b1;
        end
        OP_J: begin
          r.imm  = {6'b0, ir[25:0]};
          r.jump = 1'b1;
        end
        OP_JAL: begin
          r.imm    = {6'b0, ir[25:0]};
          r.jump   = 1'b1;
          r.is_jal = 1'b1;
          r.rd     = REG_RA;
        end
        OP_IN:   r.rd = r.rt;
        OP_OUT:  r.use_rs = 1'b1;
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic src_match(input dec_t d, input logic [5:0] r);
    return (d.use_rs && d.rs == r) || (d.use_rt && d.rt == r);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback inputs and decode/execute pipeline-register outputs of the decode stage.
// master drives fetch/execute/writeback side; slave is the decode stage itself.
interface decode_stage_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ir;
  logic        ex_busy;
  logic        ex_redirect;
  logic        wb_we;
  logic [5:0]  wb_rd;
  logic [31:0] wb_d;
  logic        stall;
  logic        de_valid;
  logic [31:0] pc;
  logic [1:0]  op_type;
  logic [5:0]  instr;
  logic [31:0] de_s;
  logic [31:0] de_t;
  logic [5:0]  de_rs;
  logic [5:0]  de_rt;
  logic [5:0]  de_rd;
  logic [31:0] imm;
  logic        branch;
  logic        jump;
  logic        is_jr;

  modport master (
    output if_valid, if_pc, if_ir, ex_busy, ex_redirect, wb_we, wb_rd, wb_d,
    input  stall, de_valid, pc, op_type, instr, de_s, de_t, de_rs, de_rt, de_rd,
           imm, branch, jump, is_jr
  );

  modport slave (
    input  if_valid, if_pc, if_ir, ex_busy, ex_redirect, wb_we, wb_rd, wb_d,
    output stall, de_valid, pc, op_type, instr, de_s, de_t, de_rs, de_rt, de_rd,
           imm, branch, jump, is_jr
  );
endinterface

// File: rtl/decode_regfile.sv
// 64x32 register file (0-31 integer, 32-63 float), 2 comb read ports, 1 write port at edge.
// Integer r0 reads zero and ignores writes; DECODE_WB_BYPASS_EN makes same-cycle writes visible.
module decode_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [5:0]  wa,
  input  logic [31:0] wd,
  input  logic [5:0]  ra0,
  input  logic [5:0]  ra1,
  output logic [31:0] rd0,
  output logic [31:0] rd1
);

  logic [31:0] mem [64];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (we && wa != 6'd0) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd0 = (ra0 == 6'd0) ? 32'd0 : mem[ra0];
    rd1 = (ra1 == 6'd0) ? 32'd0 : mem[ra1];
`ifdef DECODE_WB_BYPASS_EN
    if (we && wa != 6'd0 && wa == ra0) rd0 = wd;
    if (we && wa != 6'd0 && wa == ra1) rd1 = wd;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: 1-cycle registered decode with load-use/writeback hazard bubbles; ex_busy freezes it.
// DECODE_WB_BYPASS_EN: regfile write-through; otherwise a writeback read collision stalls one cycle.
module decode_stage
  import constant::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  dec_t        d;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        lw_pending;
  logic        load_use;
  logic        wb_haz;
  logic        hazard;
  logic        take;

  always_comb d = decode(bus.if_ir);

  decode_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (bus.wb_we),
    .wa  (bus.wb_rd),
    .wd  (bus.wb_d),
    .ra0 (d.rs),
    .ra1 (d.rt),
    .rd0 (rs_val),
    .rd1 (rt_val)
  );

  always_comb begin
    lw_pending = bus.de_valid && bus.op_type == OPTYPE_I &&
                 (bus.instr == OP_LW || bus.instr == OP_LW_S) && bus.de_rd != 6'd0;
    load_use   = lw_pending && src_match(d, bus.de_rd);
`ifdef DECODE_WB_BYPASS_EN
    wb_haz     = 1'b0;
`else
    // Without write-through the array still holds the old value this cycle.
    wb_haz     = bus.wb_we && bus.wb_rd != 6'd0 && src_match(d, bus.wb_rd);
`endif
    hazard     = bus.if_valid && !bus.ex_redirect && (load_use || wb_haz);
    take       = bus.if_valid && !bus.ex_redirect && !hazard;
    bus.stall  = !rst && (bus.ex_busy || hazard);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.de_valid <= 1'b0;
      bus.pc       <= RESET_PC;
      bus.op_type  <= '0;
      bus.instr    <= '0;
      bus.de_s     <= '0;
      bus.de_t     <= '0;
      bus.de_rs    <= '0;
      bus.de_rt    <= '0;
      bus.de_rd    <= '0;
      bus.imm      <= '0;
      bus.branch   <= 1'b0;
      bus.jump     <= 1'b0;
      bus.is_jr    <= 1'b0;
    end else if (!bus.ex_busy) begin
      bus.de_valid <= take;
      bus.pc       <= bus.if_pc;
      bus.op_type  <= d.op_type;
      bus.instr    <= d.instr;
      bus.de_s     <= d.is_jal ? bus.if_pc + 32'd4 : rs_val;
      bus.de_t     <= rt_val;
      bus.de_rs    <= d.rs;
      bus.de_rt    <= d.rt;
      // A bubble must never look like a writer to the hazard logic or execute.
      bus.de_rd    <= take ? d.rd : 6'd0;
      bus.imm      <= d.imm;
      bus.branch   <= take && d.branch;
      bus.jump     <= take && d.jump;
      bus.is_jr    <= take && d.is_jr;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  localparam logic [31:0] RST_PC   = 32'h0000_1000;
  localparam logic [31:0] I_ADDI   = 32'h2001FFFB; // addi r1,r0,-5
  localparam logic [31:0] I_ADD433 = 32'h00632020; // add r4,r3,r3
  localparam logic [31:0] I_LW     = 32'h8C220000; // lw r2,0(r1)
  localparam logic [31:0] I_ADD522 = 32'h00422820; // add r5,r2,r2
  localparam logic [31:0] I_FADD   = 32'h44430800; // fadd f1,f2,f3
  localparam logic [31:0] I_ADD600 = 32'h00003020; // add r6,r0,r0
  localparam logic [31:0] I_FADD0  = 32'h44000800; // fadd f1,f0,f0
  localparam logic [31:0] I_ORI    = 32'h34018000; // ori r1,r0,0x8000
  localparam logic [31:0] I_BEQ    = 32'h1022FFFF; // beq r1,r2,-1
  localparam logic [31:0] I_JAL    = 32'h0C000100; // jal 0x100

  decode_stage_if bus();

  decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ir);
    bus.if_valid = v;
    bus.if_pc    = p;
    bus.if_ir    = ir;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h20, I_ADDI);
    repeat (2) tick();
    checks++; if (bus.de_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.de_valid); end
    checks++; if (bus.pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%0h exp=%0h", bus.pc, RST_PC); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", bus.stall); end
    checks++; if (bus.imm !== 32'h0) begin failures++; $display("FAIL reset_imm got=%0h exp=0", bus.imm); end
    checks++; if (bus.jump !== 1'b0) begin failures++; $display("FAIL reset_jump got=%0h exp=0", bus.jump); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h10, I_ADDI);
    tick();
    checks++; if (bus.de_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", bus.de_valid); end
    checks++; if (bus.op_type !== 2'b00) begin failures++; $display("FAIL addi_optype got=%0h exp=0", bus.op_type); end
    checks++; if (bus.instr !== 6'h08) begin failures++; $display("FAIL addi_instr got=%0h exp=8", bus.instr); end
    checks++; if (bus.imm !== 32'hFFFFFFFB) begin failures++; $display("FAIL addi_imm got=%0h exp=fffffffb", bus.imm); end
    checks++; if (bus.de_rd !== 6'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", bus.de_rd); end
    checks++; if (bus.de_s !== 32'h0) begin failures++; $display("FAIL addi_s got=%0h exp=0", bus.de_s); end
    checks++; if (bus.pc !== 32'h10) begin failures++; $display("FAIL addi_pc got=%0h exp=10", bus.pc); end
  endtask

  task automatic test_wb_collision();
    drive(1'b1, 32'h14, I_ADD433);
    bus.wb_we = 1'b1; bus.wb_rd = 6'd3; bus.wb_d = 32'h1234;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL wb_stall got=%0h exp=0", bus.stall); end
    tick();
    bus.wb_we = 1'b0;
`else
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL wb_stall got=%0h exp=1", bus.stall); end
    tick();
    bus.wb_we = 1'b0;
    checks++; if (bus.de_valid !== 1'b0) begin failures++; $display("FAIL wb_bubble got=%0h exp=0", bus.de_valid); end
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL wb_stall_drop got=%0h exp=0", bus.stall); end
    tick();
`endif
    checks++; if (bus.de_valid !== 1'b1) begin failures++; $display("FAIL wb_add_valid got=%0h exp=1", bus.de_valid); end
    checks++; if (bus.de_s !== 32'h1234) begin failures++; $display("FAIL wb_add_s got=%0h exp=1234", bus.de_s); end
    checks++; if (bus.de_t !== 32'h1234) begin failures++; $display("FAIL wb_add_t got=%0h exp=1234", bus.de_t); end
    checks++; if (bus.op_type !== 2'b01 || bus.instr !== 6'h20) begin failures++; $display("FAIL wb_add_type got=%0h/%0h exp=1/20", bus.op_type, bus.instr); end
    checks++; if (bus.de_rd !== 6'd4) begin failures++; $display("FAIL wb_add_rd got=%0d exp=4", bus.de_rd); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h18, I_LW);
    tick();
    checks++; if (bus.instr !== 6'h23 || bus.de_rd !== 6'd2) begin failures++; $display("FAIL lu_lw got=%0h/%0d exp=23/2", bus.instr, bus.de_rd); end
    drive(1'b1, 32'h1C, I_ADD522);
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", bus.stall); end
    tick();
    checks++; if (bus.de_valid !== 1'b0 || bus.de_rd !== 6'd0) begin failures++; $display("FAIL lu_bubble got=%0h/%0d exp=0/0", bus.de_valid, bus.de_rd); end
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_stall_drop got=%0h exp=0", bus.stall); end
    tick();
    checks++; if (bus.de_valid !== 1'b1 || bus.de_rd !== 6'd5) begin failures++; $display("FAIL lu_add got=%0h/%0d exp=1/5", bus.de_valid, bus.de_rd); end
    checks++; if (bus.pc !== 32'h1C || bus.de_rs !== 6'd2) begin failures++; $display("FAIL lu_add_pc got=%0h/%0d exp=1c/2", bus.pc, bus.de_rs); end
  endtask

  task automatic test_fpu();
    drive(1'b1, 32'h20, I_FADD);
    bus.wb_we = 1'b1; bus.wb_rd = 6'd0; bus.wb_d = 32'hDEAD;
    tick();
    checks++; if (bus.op_type !== 2'b10 || bus.instr !== 6'h00) begin failures++; $display("FAIL fpu_type got=%0h/%0h exp=2/0", bus.op_type, bus.instr); end
    checks++; if (bus.de_rs !== 6'd34 || bus.de_rt !== 6'd35) begin failures++; $display("FAIL fpu_src got=%0d/%0d exp=34/35", bus.de_rs, bus.de_rt); end
    checks++; if (bus.de_rd !== 6'd33) begin failures++; $display("FAIL fpu_rd got=%0d exp=33", bus.de_rd); end
    drive(1'b1, 32'h24, I_ADD600);
    bus.wb_rd = 6'd32; bus.wb_d = 32'h55;
    tick();
    bus.wb_we = 1'b0;
    checks++; if (bus.de_s !== 32'h0 || bus.de_t !== 32'h0) begin failures++; $display("FAIL r0_zero got=%0h/%0h exp=0/0", bus.de_s, bus.de_t); end
    drive(1'b1, 32'h28, I_FADD0);
    tick();
    checks++; if (bus.de_s !== 32'h55 || bus.de_rs !== 6'd32) begin failures++; $display("FAIL f0_read got=%0h/%0d exp=55/32", bus.de_s, bus.de_rs); end
  endtask

  task automatic test_imm_branch();
    drive(1'b1, 32'h2C, I_ORI);
    tick();
    checks++; if (bus.imm !== 32'h00008000 || bus.instr !== 6'h0d) begin failures++; $display("FAIL ori_imm got=%0h/%0h exp=8000/d", bus.imm, bus.instr); end
    checks++; if (bus.branch !== 1'b0 || bus.de_rd !== 6'd1) begin failures++; $display("FAIL ori_rd got=%0h/%0d exp=0/1", bus.branch, bus.de_rd); end
    drive(1'b1, 32'h30, I_BEQ);
    tick();
    checks++; if (bus.branch !== 1'b1 || bus.imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL beq got=%0h/%0h exp=1/ffffffff", bus.branch, bus.imm); end
    checks++; if (bus.de_rd !== 6'd0 || bus.de_rt !== 6'd2) begin failures++; $display("FAIL beq_regs got=%0d/%0d exp=0/2", bus.de_rd, bus.de_rt); end
  endtask

  task automatic test_jal_redirect();
    drive(1'b1, 32'h40, I_JAL);
    tick();
    checks++; if (bus.jump !== 1'b1 || bus.imm !== 32'h100) begin failures++; $display("FAIL jal got=%0h/%0h exp=1/100", bus.jump, bus.imm); end
    checks++; if (bus.de_s !== 32'h44 || bus.de_rd !== 6'd31) begin failures++; $display("FAIL jal_link got=%0h/%0d exp=44/31", bus.de_s, bus.de_rd); end
    drive(1'b1, 32'h44, I_ADDI);
    bus.ex_redirect = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL redir_stall got=%0h exp=0", bus.stall); end
    tick();
    bus.ex_redirect = 1'b0;
    checks++; if (bus.de_valid !== 1'b0 || bus.jump !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%0h/%0h exp=0/0", bus.de_valid, bus.jump); end
  endtask

  task automatic test_busy();
    drive(1'b1, 32'h80, I_ADDI);
    tick();
    drive(1'b1, 32'h84, I_ORI);
    bus.ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_redirect = (i == 1);
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL busy_stall[%0d] got=%0h exp=1", i, bus.stall); end
      tick();
      checks++; if (bus.pc !== 32'h80 || bus.instr !== 6'h08 || bus.de_valid !== 1'b1 || bus.imm !== 32'hFFFFFFFB) begin
        failures++; $display("FAIL busy_hold[%0d] got=%0h/%0h/%0h exp=80/8/1", i, bus.pc, bus.instr, bus.de_valid);
      end
    end
    bus.ex_busy = 1'b0;
    bus.ex_redirect = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL busy_release_stall got=%0h exp=0", bus.stall); end
    tick();
    checks++; if (bus.pc !== 32'h84 || bus.instr !== 6'h0d || bus.de_valid !== 1'b1) begin failures++; $display("FAIL busy_resume got=%0h/%0h/%0h exp=84/d/1", bus.pc, bus.instr, bus.de_valid); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h90, I_LW);
    tick();
    drive(1'b1, 32'h94, I_ADD522);
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL rms_stall got=%0h exp=1", bus.stall); end
    rst = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rms_stall_in_rst got=%0h exp=0", bus.stall); end
    tick();
    rst = 1'b0;
    checks++; if (bus.de_valid !== 1'b0 || bus.pc !== RST_PC) begin failures++; $display("FAIL rms_out got=%0h/%0h exp=0/1000", bus.de_valid, bus.pc); end
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rms_stall_after got=%0h exp=0", bus.stall); end
    tick();
    checks++; if (bus.de_valid !== 1'b1 || bus.instr !== 6'h20) begin failures++; $display("FAIL rms_add got=%0h/%0h exp=1/20", bus.de_valid, bus.instr); end
    drive(1'b1, 32'h98, I_ADD433);
    tick();
    checks++; if (bus.de_s !== 32'h0) begin failures++; $display("FAIL rms_rf_cleared got=%0h exp=0", bus.de_s); end
  endtask

  initial begin
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_ir = '0;
    bus.ex_busy = 1'b0; bus.ex_redirect = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_d = '0;
    test_reset();
    test_addi();
    test_wb_collision();
    test_load_use();
    test_fpu();
    test_imm_branch();
    test_jal_redirect();
    test_busy();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
